muldiv_ctrl: RTL and testbench

- Sequencer and owner of the HI/LO resource for the stage-3 multiply/divide instructions: mult, multu, div, divu, mthi, mtlo, mfhi, mflo.
- Sits beside the ALU in EX. Accepts one operation at a time through a valid/ready handshake and runs a multi-cycle multiply or an iterative divide.
- Raises a pipeline stall when the pipeline offers a new op, or reads HI/LO, while an operation is still in flight.

---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/div_iter.sv | 50 +++++
 rtl/muldiv_ctrl.sv | 168 ++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants for the multiply/divide sequencer: op codes, FSM states,
// divider iteration count and a sign-correction helper.
package muldiv_pkg;

  localparam int DIV_ITER = 32;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/div_iter.sv
// 32-bit restoring divider datapath: one step per step_i, results of the
// current step are presented combinationally so the caller can commit them.
module div_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] quot_o,
  output logic [31:0] rem_o
);

  logic [31:0] rem_q, rem_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] dvsr_q;
  logic [32:0] shifted, diff;

  // quot_q starts as the dividend; its MSBs shift out as quotient bits shift in.
  always_comb begin
    shifted = {rem_q, quot_q[31]};
    diff    = shifted - {1'b0, dvsr_q};
    if (!diff[32]) begin
      rem_d  = diff[31:0];
      quot_d = {quot_q[30:0], 1'b1};
    end else begin
      rem_d  = shifted[31:0];
      quot_d = {quot_q[30:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= 32'd0;
      quot_q <= 32'd0;
      dvsr_q <= 32'd0;
    end else if (load_i) begin
      rem_q  <= 32'd0;
      quot_q <= dividend_i;
      dvsr_q <= divisor_i;
    end else if (step_i) begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
    end
  end

  assign quot_o = quot_d;
  assign rem_o  = rem_d;

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO owner and sequencer for mult/multu/div/divu/mthi/mtlo with stall logic.
// Optional MULDIV_DIV0_FAST_EN: divide by zero completes at the accept edge.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  op_type,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        op_ready,
  input  logic        rd_hi_req,
  input  logic        rd_lo_req,
  output logic [31:0] rd_data,
  output logic        stall,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] ma_q, ma_d, mb_q, mb_d;
  logic        msgn_q, msgn_d, qneg_q, qneg_d, rneg_q, rneg_d;

  logic        accept, is_mul, is_div, div_sgn, a_neg, b_neg, div0_fast;
  logic        div_load, div_step;
  logic [31:0] abs_a, abs_b, quot, rem;
  logic signed [32:0] mul_a, mul_b;
  logic signed [63:0] prod;

  assign accept  = op_valid & op_ready;
  assign is_mul  = (op_type == OP_MULT) | (op_type == OP_MULTU);
  assign is_div  = (op_type == OP_DIV)  | (op_type == OP_DIVU);
  assign div_sgn = (op_type == OP_DIV);
  assign a_neg   = div_sgn & src_a[31];
  assign b_neg   = div_sgn & src_b[31];
  assign abs_a   = neg_if(src_a, a_neg);
  assign abs_b   = neg_if(src_b, b_neg);

`ifdef MULDIV_DIV0_FAST_EN
  assign div0_fast = (src_b == 32'd0);
`else
  assign div0_fast = 1'b0;
`endif

  // 33x33 signed product; the low 64 bits are all HI/LO needs.
  assign mul_a = {msgn_q & ma_q[31], ma_q};
  assign mul_b = {msgn_q & mb_q[31], mb_q};
  assign prod  = 64'(mul_a) * 64'(mul_b);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && is_mul)                 state_d = ST_MUL;
        else if (accept && is_div && !div0_fast) state_d = ST_DIV;
      end
      ST_MUL, ST_DIV: if (cnt_q == 6'd0) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    op_ready = (state_q == ST_IDLE);
    busy     = (state_q != ST_IDLE);
  end

  always_comb begin
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    msgn_d   = msgn_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    div_load = 1'b0;
    div_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept && is_mul) begin
          ma_d   = src_a;
          mb_d   = src_b;
          msgn_d = (op_type == OP_MULT);
          cnt_d  = 6'(MUL_LAT - 1);
        end else if (accept && is_div) begin
          qneg_d = a_neg ^ b_neg;
          rneg_d = a_neg;
          if (div0_fast) begin
            lo_d = neg_if(32'hFFFF_FFFF, a_neg ^ b_neg);
            hi_d = neg_if(abs_a, a_neg);
          end else begin
            div_load = 1'b1;
            cnt_d    = 6'(DIV_ITER - 1);
          end
        end else if (accept && op_type == OP_MTHI) begin
          hi_d = src_a;
        end else if (accept && op_type == OP_MTLO) begin
          lo_d = src_a;
        end
      end
      ST_MUL: begin
        if (cnt_q == 6'd0) {hi_d, lo_d} = prod;
        else               cnt_d = cnt_q - 6'd1;
      end
      ST_DIV: begin
        div_step = 1'b1;
        if (cnt_q == 6'd0) begin
          lo_d = neg_if(quot, qneg_q);
          hi_d = neg_if(rem, rneg_q);
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= 6'd0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      ma_q   <= 32'd0;
      mb_q   <= 32'd0;
      msgn_q <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      ma_q   <= ma_d;
      mb_q   <= mb_d;
      msgn_q <= msgn_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
    end
  end

  div_iter u_div_iter (
    .clk        (clk),
    .rst        (rst),
    .load_i     (div_load),
    .step_i     (div_step),
    .dividend_i (abs_a),
    .divisor_i  (abs_b),
    .quot_o     (quot),
    .rem_o      (rem)
  );

  // Reads only ever see committed HI/LO; in-flight results are never bypassed.
  assign rd_data = rd_hi_req ? hi_q : lo_q;
  assign stall   = (op_valid & ~op_ready) | ((rd_hi_req | rd_lo_req) & busy);
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed cases plus random ops against
// a latency/arithmetic model of the HI/LO unit.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  localparam int MUL_LAT = 2;

  logic        clk, rst;
  logic        op_valid;
  logic [2:0]  op_type;
  logic [31:0] src_a, src_b;
  logic        op_ready;
  logic        rd_hi_req, rd_lo_req;
  logic [31:0] rd_data;
  logic        stall, busy;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;

  // Model state
  logic [63:0] exp_q[$];
  logic [31:0] m_hi, m_lo;
  int          m_rem;
  bit          started = 0;
  bit          rnd_rd = 0;

  muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .op_valid  (op_valid),
    .op_type   (op_type),
    .src_a     (src_a),
    .src_b     (src_b),
    .op_ready  (op_ready),
    .rd_hi_req (rd_hi_req),
    .rd_lo_req (rd_lo_req),
    .rd_data   (rd_data),
    .stall     (stall),
    .busy      (busy),
    .hi        (hi),
    .lo        (lo)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural result {hi,lo} of a mult/div, straight from the arithmetic rules.
  function automatic logic [63:0] exp_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = 64'd0;
    case (op)
      OP_MULT:  p = 64'(sa * sb);
      OP_MULTU: p = {32'd0, a} * {32'd0, b};
      OP_DIVU:  p = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      OP_DIV: begin
        if (b == 32'd0)
          p = {a, (a[31] ? 32'd1 : 32'hFFFF_FFFF)};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          p = {32'd0, 32'h8000_0000};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      default: p = 64'd0;
    endcase
    return p;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one op in flight, results land a fixed number of edges later.
  always @(posedge clk) begin
    logic [63:0] r;
    if (rst) begin
      m_hi = 32'd0;
      m_lo = 32'd0;
      m_rem = 0;
      exp_q.delete();
      started = 1;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin
        r = exp_q.pop_front();
        m_hi = r[63:32];
        m_lo = r[31:0];
      end
    end else if (op_valid) begin
      case (op_type)
        OP_MULT, OP_MULTU: begin
          exp_q.push_back(exp_result(op_type, src_a, src_b));
          m_rem = MUL_LAT;
        end
        OP_DIV, OP_DIVU: begin
`ifdef MULDIV_DIV0_FAST_EN
          if (src_b == 32'd0) begin
            r = exp_result(op_type, src_a, src_b);
            m_hi = r[63:32];
            m_lo = r[31:0];
          end else
`endif
          begin
            exp_q.push_back(exp_result(op_type, src_a, src_b));
            m_rem = DIV_ITER;
          end
        end
        OP_MTHI: m_hi = src_a;
        OP_MTLO: m_lo = src_a;
        default: ;
      endcase
    end
  end

  // Compare process, away from the active edge
  always @(negedge clk) begin
    if (started) begin
      chk("op_ready", {31'd0, op_ready}, {31'd0, m_rem == 0});
      chk("busy", {31'd0, busy}, {31'd0, m_rem != 0});
      chk("stall", {31'd0, stall},
          {31'd0, (op_valid && m_rem != 0) || ((rd_hi_req || rd_lo_req) && m_rem != 0)});
      chk("rd_data", rd_data, rd_hi_req ? m_hi : m_lo);
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
    end
  end

  // Driver tasks
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    bit done;
    n = 0;
    done = 0;
    op_valid = 1'b1;
    op_type  = op;
    src_a    = a;
    src_b    = b;
    while (!done && n < 200) begin
      @(negedge clk);
      done = op_ready;
      @(posedge clk);
      #1;
      n++;
    end
    op_valid = 1'b0;
    op_type  = 3'($urandom_range(0, 7));
    src_a    = $urandom;
    src_b    = $urandom;
    chk("issue_accept", {31'd0, done}, 32'd1);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    forever begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (n >= 100) begin
        chk("idle_timeout", 32'(n), 32'd0);
        break;
      end
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_rd) begin
        rd_hi_req = 1'($urandom_range(0, 1));
        rd_lo_req = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    int n;
    int div0_lat;
    logic [2:0] op;
    rst = 1'b1;
    op_valid = 1'b0;
    op_type = OP_NONE;
    src_a = 32'd0;
    src_b = 32'd0;
    rd_hi_req = 1'b0;
    rd_lo_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_ready", {31'd0, op_ready}, 32'd1);
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_rd_data", rd_data, 32'd0);
    @(posedge clk); #1;

    issue(OP_MULT, 32'hFFFF_FFFF, 32'd2);
    wait_idle(n);
    chk("mult_latency", 32'(n), 32'(MUL_LAT));
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFE);

    issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    wait_idle(n);
    chk("multu_hi", hi, 32'd1);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    chk("div_latency", 32'(n), 32'd32);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    issue(OP_DIVU, 32'd7, 32'd2);
    wait_idle(n);
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd1);

    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'd0);

    issue(OP_DIVU, 32'd5, 32'd0);
    wait_idle(n);
`ifdef MULDIV_DIV0_FAST_EN
    div0_lat = 0;
`else
    div0_lat = 32;
`endif
    chk("div0_latency", 32'(n), 32'(div0_lat));
    chk("div0_lo", lo, 32'hFFFF_FFFF);
    chk("div0_hi", hi, 32'd5);

    // mflo while a divide is in flight
    issue(OP_DIV, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    #1 rd_lo_req = 1'b1;
    @(negedge clk);
    chk("mflo_stall", {31'd0, stall}, 32'd1);
    wait_idle(n);
    chk("mflo_data", rd_data, 32'd14);
    chk("mflo_hi", hi, 32'd2);
    @(posedge clk);
    #1 rd_lo_req = 1'b0;

    // mthi waits behind a busy mult
    issue(OP_MULT, 32'd3, 32'd5);
    issue(OP_MTHI, 32'h1234, 32'd0);
    chk("mthi_hi", hi, 32'h1234);
    chk("mthi_lo", lo, 32'd15);

    // reset in the middle of a divide
    issue(OP_DIV, 32'd100, 32'd7);
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rstmid_hi", hi, 32'd0);
    chk("rstmid_lo", lo, 32'd0);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_ready", {31'd0, op_ready}, 32'd1);
    @(posedge clk); #1;

    // random traffic
    rnd_rd = 1;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      case ($urandom_range(0, 11))
        0:      op = OP_NONE;
        1, 2:   op = OP_MULT;
        3:      op = OP_MULTU;
        4, 5:   op = OP_DIV;
        6, 7:   op = OP_DIVU;
        8:      op = OP_MTHI;
        9:      op = OP_MTLO;
        10:     op = 3'd7;
        default: op = OP_DIV;
      endcase
      issue(op, pick_operand(), pick_operand());
      if (i % 60 == 59) begin
        repeat ($urandom_range(0, 20)) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
      end
    end
    wait_idle(n);
    rnd_rd = 0;
    repeat (2) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
